phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
Control FSM that sequences a multi-phase operation through a 4-bit state encoding. It computes next_state and holds it in its own 4-bit state register (current_state). Each phase runs a req/ack handshake with a downstream unit, has a programmable minimum dwell, and a timeout watchdog. Software/top-level control drives it through start/pause/abort; status goes back as busy/done/fault.

Parameters:
N_PHASES, 3, number of active phases; legal range 1..13 (encodings 4'h1..N_PHASES)
CNT_W, 8, width of the in-phase cycle counter and dwell_len
TIMEOUT, 10, cycles allowed per phase before fault; 2 <= TIMEOUT <= 2**CNT_W-1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin sequence; sampled only in IDLE
pause  in  1  level; freezes state and counter while high
abort  in  1  level; forces return to IDLE
phase_ack  in  1  downstream acknowledge for current phase
dwell_len  in  CNT_W  minimum in-phase cycles; sampled on phase entry
current_state  out  4  registered FSM state
phase_req  out  1  request to downstream unit for current phase
busy  out  1  high in any PHASE_k state
done  out  1  high for exactly the one cycle state==DONE
fault  out  1  high while state==FAULT

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: current_state=IDLE(4'h0), cnt=0, ack_seen=0, dwell_q=0; all outputs 0.
- Encoding: IDLE 4'h0; PHASE_k 4'h1..N_PHASES; DONE 4'hE; FAULT 4'hF. Unused codes -> IDLE next cycle.
- Priority per cycle: reset > abort > pause > advance > timeout.
- IDLE: start=1 -> PHASE_1 next cycle (latency 1). start ignored in all other states.
- Phase entry: cnt<=0, ack_seen<=0, dwell_q<=dwell_len.
- In PHASE_k (not paused): phase_req=1; cnt increments (saturating at 2**CNT_W-1); ack_seen sets on phase_ack=1 and is sticky for the phase.
- Advance when cnt>=dwell_q and (ack_seen or phase_ack): PHASE_k -> PHASE_k+1, or PHASE_N_PHASES -> DONE. Phase lasts max(dwell_q, ack cycle)+1 cycles. dwell_len=0 with ack already high -> 1-cycle phase.
- Timeout: cnt==TIMEOUT-1 and no advance -> FAULT. Advance wins on the same cycle. dwell_q>=TIMEOUT always faults.
- pause=1 in PHASE_k: state, cnt, ack_seen frozen; phase_req=0; phase_ack ignored. pause has no effect in IDLE, DONE or FAULT.
- DONE: done=1 for one cycle, then IDLE unconditionally, even if start=1.
- FAULT: sticky; exits only via abort (-> IDLE) or reset.
- abort=1 in any state -> IDLE next cycle with counters cleared. abort and start together in IDLE -> stays IDLE.
- Outputs are decoded from registered current_state/pause only; no combinational path from phase_ack to any output.

Decomposition:
- Shared package: state encoding localparams (ST_IDLE, ST_DONE, ST_FAULT, ST_PHASE_BASE) and the 4-bit state type width. The current-state decoder and testbench both use it.
- One sub-module: phase_timer (cnt, dwell_q, ack_seen, clear/hold/enable inputs, dwell_met/timeout outputs). FSM next-state logic and state register stay in phase_sequencer.

Test Plan:
- Nominal (N_PHASES=3, dwell_len=2, TIMEOUT=10, phase_ack held 1, start at cycle 0) -> state 1 in cycles 1-3, 2 in 4-6, 3 in 7-9, DONE (done=1) at 10, IDLE at 11.
- Late ack (dwell_len=0, ack pulsed at 4th cycle of PHASE_1) -> PHASE_2 the cycle after the ack. Pulse held by ack_seen when dwell_len=5 -> advance at cnt=5.
- Timeout (phase_ack=0, TIMEOUT=10) -> FAULT 10 cycles after entering PHASE_1, fault=1 sticky; start ignored; abort -> IDLE next cycle.
- Pause (pause high 4 cycles mid PHASE_2, ack=1, dwell=2) -> phase_req=0 and cnt frozen during pause; PHASE_2 lasts 3 active cycles total; no timeout.
- Ack and timeout on the same cycle (ack first at cnt=TIMEOUT-1) -> advance, no FAULT. abort+pause together -> IDLE.
- Reset asserted mid-PHASE_2 and in FAULT -> next cycle all outputs 0, current_state=4'h0; forced illegal code 4'hB -> IDLE.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer_pkg
// Description : State encoding shared by the phase sequencer, its timer and
//               anything that decodes current_state.
// Revision    : 1.0 - initial release
// ============================================================================
package phase_sequencer_pkg;

    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    // Phase codes 4'h1..N_PHASES sit between IDLE and DONE and are not
    // enumerated because their count is a parameter of the sequencer.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 4'h0,
        ST_PHASE_BASE = 4'h1,
        ST_DONE       = 4'hE,
        ST_FAULT      = 4'hF
    } state_e;

    function automatic logic is_phase(input state_t s, input int n_phases);
        return (s >= ST_PHASE_BASE) && (int'(s) <= n_phases);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer_if
// Description : Control/status bundle between a controller and the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface phase_sequencer_if #(
    parameter int CNT_W = 8
);
    import phase_sequencer_pkg::*;

    logic             start;
    logic             pause;
    logic             abort;
    logic             phase_ack;
    logic [CNT_W-1:0] dwell_len;
    state_t           current_state;
    logic             phase_req;
    logic             busy;
    logic             done;
    logic             fault;

    modport master (
        output start, pause, abort, phase_ack, dwell_len,
        input  current_state, phase_req, busy, done, fault
    );

    modport slave (
        input  start, pause, abort, phase_ack, dwell_len,
        output current_state, phase_req, busy, done, fault
    );

endinterface
`default_nettype wire

// File: rtl/phase_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Per-phase cycle counter, latched dwell and sticky ack flag;
//               reports dwell satisfied, ack observed and watchdog expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_load,
    input  wire logic             i_enable,
    input  wire logic             i_phase_ack,
    input  wire logic [CNT_W-1:0] i_dwell_len,
    output logic                  o_dwell_met,
    output logic                  o_ack_ok,
    output logic                  o_timeout
);

    localparam logic [CNT_W-1:0] c_cnt_max      = '1;
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dwell_q;
    logic             r_ack_seen;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt      <= '0;
            r_dwell_q  <= '0;
            r_ack_seen <= 1'b0;
        end else if (i_load) begin
            r_cnt      <= '0;
            r_dwell_q  <= i_dwell_len;
            r_ack_seen <= 1'b0;
        end else if (i_enable) begin
            if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_phase_ack) begin
                r_ack_seen <= 1'b1;
            end
        end
    end

    // The live ack counts in its own cycle so an early ack costs no extra cycle.
    assign o_dwell_met = (r_cnt >= r_dwell_q);
    assign o_ack_ok    = r_ack_seen | i_phase_ack;
    assign o_timeout   = (r_cnt == c_timeout_last);

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Sequences N_PHASES req/ack phases with minimum dwell and a
//               per-phase watchdog; start/pause/abort control, busy/done/fault.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int N_PHASES = 3,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    phase_sequencer_if.slave   bus
);

    localparam state_t c_last_phase = state_t'(N_PHASES);

    state_t r_state;

    logic w_in_phase;
    logic w_active;
    logic w_dwell_met;
    logic w_ack_ok;
    logic w_timeout;
    logic w_advance;
    logic w_enter_phase;

    assign w_in_phase    = is_phase(r_state, N_PHASES);
    assign w_active      = w_in_phase & ~bus.pause & ~bus.abort;
    assign w_advance     = w_active & w_dwell_met & w_ack_ok;
    assign w_enter_phase = ((r_state == ST_IDLE) & bus.start & ~bus.abort) |
                           (w_advance & (r_state != c_last_phase));

    phase_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (bus.abort),
        .i_load      (w_enter_phase),
        .i_enable    (w_active),
        .i_phase_ack (bus.phase_ack),
        .i_dwell_len (bus.dwell_len),
        .o_dwell_met (w_dwell_met),
        .o_ack_ok    (w_ack_ok),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_PHASE_BASE;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                ST_FAULT: r_state <= ST_FAULT;
                default: begin
                    // Unused codes fall back to IDLE; advance beats the watchdog.
                    if (!w_in_phase) begin
                        r_state <= ST_IDLE;
                    end else if (w_advance) begin
                        r_state <= (r_state == c_last_phase) ? state_t'(ST_DONE)
                                                             : r_state + 1'b1;
                    end else if (w_active && w_timeout) begin
                        r_state <= ST_FAULT;
                    end
                end
            endcase
        end
    end

    assign bus.current_state = r_state;
    assign bus.busy          = w_in_phase;
    assign bus.phase_req     = w_in_phase & ~bus.pause;
    assign bus.done          = (r_state == ST_DONE);
    assign bus.fault         = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Self-checking bench for phase_sequencer (vector table, corner
//               sequences and random traffic against a behavioural model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;
    import phase_sequencer_pkg::*;

    localparam int N_PHASES = 3;
    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 10;

    logic clk;
    logic reset;

    phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

    phase_sequencer #(
        .N_PHASES (N_PHASES),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: which phase we are in, how long it has been active,
    // whether an ack has been seen, and the dwell latched on entry.
    int m_phase;
    int m_elapsed;
    int m_min;
    bit m_acked;
    bit m_done;
    bit m_fault;

    typedef struct {
        bit         r, s, p, a, k;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] pk(input int st, input bit req, busy, dn, flt);
        logic [3:0] s4;
        s4 = st[3:0];
        return {s4, req, busy, dn, flt};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.current_state, bus.phase_req, bus.busy, bus.done, bus.fault};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {state,req,busy,done,fault}=%h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input int exp);
        logic [3:0] e4;
        e4 = exp[3:0];
        n_checks++;
        if (bus.current_state !== e4) begin
            n_fail++;
            $display("FAIL %s: current_state got %h expected %h at %0t",
                     name, bus.current_state, e4, $time);
        end
    endtask

    task automatic model_enter(input int ph, input logic [7:0] d);
        m_phase   = ph;
        m_elapsed = 0;
        m_acked   = 1'b0;
        m_min     = int'(d);
    endtask

    task automatic model_step(input bit r, s, p, a, k, input logic [7:0] d);
        if (r || a) begin
            m_phase = 0; m_done = 0; m_fault = 0;
            m_elapsed = 0; m_acked = 0; m_min = 0;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_phase == 0) begin
            if (s) model_enter(1, d);
        end else if (!p) begin
            if (m_elapsed >= m_min && (m_acked || k)) begin
                if (m_phase == N_PHASES) begin
                    m_phase = 0;
                    m_done  = 1'b1;
                end else begin
                    model_enter(m_phase + 1, d);
                end
            end else if (m_elapsed == TIMEOUT - 1) begin
                m_phase = 0;
                m_fault = 1'b1;
            end else begin
                m_elapsed = (m_elapsed < 255) ? m_elapsed + 1 : 255;
                m_acked   = m_acked | k;
            end
        end
    endtask

    function automatic logic [7:0] model_out(input bit p);
        int st;
        st = m_fault ? 15 : (m_done ? 14 : m_phase);
        return pk(st, (m_phase != 0) && !p, m_phase != 0, m_done, m_fault);
    endfunction

    // Drive one cycle of inputs, clock the DUT and compare against the model.
    task automatic cycle(input bit r, s, p, a, k, input logic [7:0] d);
        @(negedge clk);
        reset         = r;
        bus.start     = s;
        bus.pause     = p;
        bus.abort     = a;
        bus.phase_ack = k;
        bus.dwell_len = d;
        model_step(r, s, p, a, k, d);
        @(posedge clk);
        #1;
        check("model", dut_out(), model_out(p));
    endtask

    task automatic add(input bit r, s, p, a, k, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.a = a; v.k = k; v.d = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.pause = 0; bus.abort = 0; bus.phase_ack = 0; bus.dwell_len = '0;
        m_phase = 0; m_elapsed = 0; m_min = 0; m_acked = 0; m_done = 0; m_fault = 0;

        // Nominal run plus control corner cases, one record per clock.
        add(1,0,0,0,0,0, pk(0,0,0,0,0));
        add(0,1,0,0,1,2, pk(1,1,1,0,0));
        repeat (2) add(0,0,0,0,1,2, pk(1,1,1,0,0));
        repeat (3) add(0,0,0,0,1,2, pk(2,1,1,0,0));
        repeat (3) add(0,0,0,0,1,2, pk(3,1,1,0,0));
        add(0,0,0,0,1,2, pk(14,0,0,1,0));
        add(0,1,0,0,1,2, pk(0,0,0,0,0));
        add(0,1,0,1,0,0, pk(0,0,0,0,0));
        add(0,1,0,0,0,0, pk(1,1,1,0,0));
        add(0,0,1,1,0,0, pk(0,0,0,0,0));
        add(0,1,0,0,0,0, pk(1,1,1,0,0));
        add(0,0,1,0,1,0, pk(1,0,1,0,0));
        add(1,0,0,0,0,0, pk(0,0,0,0,0));

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].a, vecs[i].k, vecs[i].d);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Late ack with zero dwell, then a single ack pulse held across dwell 5.
        cycle(1,0,0,0,0,0);
        cycle(0,1,0,0,0,0);
        repeat (3) cycle(0,0,0,0,0,0);
        check_state("late_ack_hold", 1);
        cycle(0,0,0,0,1,5);
        check_state("late_ack_adv", 2);
        cycle(0,0,0,0,1,0);
        repeat (4) cycle(0,0,0,0,0,0);
        check_state("ack_seen_hold", 2);
        cycle(0,0,0,0,0,0);
        check_state("ack_seen_adv", 3);
        cycle(0,0,0,1,0,0);

        // Watchdog: fault is sticky against start and pause, cleared by abort.
        cycle(0,1,0,0,0,0);
        repeat (9) cycle(0,0,0,0,0,0);
        check_state("timeout_pre", 1);
        cycle(0,0,0,0,0,0);
        check("timeout_fault", dut_out(), pk(15,0,0,0,1));
        cycle(0,1,0,0,0,0);
        check_state("fault_start", 15);
        cycle(0,0,1,0,0,0);
        check_state("fault_pause", 15);
        cycle(0,0,0,1,0,0);
        check("fault_abort", dut_out(), pk(0,0,0,0,0));
        cycle(0,1,0,0,0,0);
        repeat (10) cycle(0,0,0,0,0,0);
        check_state("fault_again", 15);
        cycle(1,0,0,0,0,0);
        check("fault_reset", dut_out(), pk(0,0,0,0,0));

        // Pause mid PHASE_2 freezes the phase; it still needs 3 active cycles.
        cycle(0,1,0,0,1,2);
        repeat (3) cycle(0,0,0,0,1,2);
        check_state("pause_enter2", 2);
        cycle(0,0,0,0,1,2);
        repeat (4) begin
            cycle(0,0,1,0,1,2);
            check("pause_frozen", dut_out(), pk(2,0,1,0,0));
        end
        cycle(0,0,0,0,1,2);
        check_state("pause_resume", 2);
        cycle(0,0,0,0,1,2);
        check_state("pause_adv", 3);

        // First ack on the watchdog cycle wins; then reset mid PHASE_2.
        cycle(1,0,0,0,0,0);
        cycle(0,1,0,0,0,0);
        repeat (9) cycle(0,0,0,0,0,0);
        cycle(0,0,0,0,1,0);
        check("ack_at_timeout", dut_out(), pk(2,1,1,0,0));
        cycle(1,0,0,0,0,0);
        check("reset_phase2", dut_out(), pk(0,0,0,0,0));

        // Unused encoding recovers to IDLE.
        force dut.r_state = 4'hB;
        #1;
        release dut.r_state;
        cycle(0,0,0,0,0,0);
        check("illegal_code", dut_out(), pk(0,0,0,0,0));

        // Random traffic against the model.
        cycle(1,0,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 2) == 0),
                  8'($urandom_range(0, 11)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
